// File: rtl/chacha_pkg.sv
// -----------------------------------------------------------------------------
// chacha_pkg
// Shared definitions for the ChaCha20 block sequencer:
//   - the four ChaCha "expand 32-byte k" constant words (state words 0..3)
//   - the sequencer state enumeration
//   - word indices of the key, counter and nonce fields in the 16-word state
//   - const_word(): returns constant word 0..3
// -----------------------------------------------------------------------------
package chacha_pkg;

  localparam logic [31:0] CONST_W0 = 32'h61707865;
  localparam logic [31:0] CONST_W1 = 32'h3320646e;
  localparam logic [31:0] CONST_W2 = 32'h79622d32;
  localparam logic [31:0] CONST_W3 = 32'h6b206574;

  // Word indices inside the 16-word ChaCha state
  localparam logic [3:0] KEY_BASE   = 4'd4;
  localparam logic [3:0] CTR_W      = 4'd12;
  localparam logic [3:0] NONCE_BASE = 4'd13;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CALC   = 3'd2,
    STREAM = 3'd3,
    NEXT   = 3'd4
  } seq_state_e;

  function automatic logic [31:0] const_word(input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = CONST_W0;
      2'd1:    w = CONST_W1;
      2'd2:    w = CONST_W2;
      default: w = CONST_W3;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/chacha_state_byte_mux.sv
// -----------------------------------------------------------------------------
// chacha_state_byte_mux
// Combinational lookup of one byte of the initial ChaCha state. Byte address
// a = 4*w + b selects byte b (little-endian) of state word w, where
//   w0..3 = constants, w4..11 = key words 0..7, w12 = counter,
//   w13..15 = nonce words 0..2.
// Ports:
//   addr_i  [5:0]   byte address 0..63
//   key_i   [255:0] key, word k = key_i[32k+31:32k]
//   nonce_i [95:0]  nonce, word n = nonce_i[32n+31:32n]
//   ctr_i   [31:0]  block counter
//   byte_o  [7:0]   state byte at addr_i
// -----------------------------------------------------------------------------
module chacha_state_byte_mux
  import chacha_pkg::*;
(
  input  logic [5:0]   addr_i,
  input  logic [255:0] key_i,
  input  logic [95:0]  nonce_i,
  input  logic [31:0]  ctr_i,
  output logic [7:0]   byte_o
);

  logic [3:0]  word_idx;
  logic [2:0]  key_off;
  logic [1:0]  nonce_off;
  logic [31:0] word_sel;

  assign word_idx = addr_i[5:2];
  // Offsets wrap naturally: words 4..11 map to key words 0..7 and
  // words 13..15 map to nonce words 0..2 using only the low index bits.
  assign key_off   = word_idx[2:0] - KEY_BASE[2:0];
  assign nonce_off = word_idx[1:0] - NONCE_BASE[1:0];

  always_comb begin
    word_sel = 32'h0;
    if (word_idx < KEY_BASE) begin
      word_sel = const_word(word_idx[1:0]);
    end else if (word_idx < CTR_W) begin
      word_sel = key_i[{key_off, 5'b00000} +: 32];
    end else if (word_idx == CTR_W) begin
      word_sel = ctr_i;
    end else begin
      case (nonce_off)
        2'd0:    word_sel = nonce_i[31:0];
        2'd1:    word_sel = nonce_i[63:32];
        default: word_sel = nonce_i[95:64];
      endcase
    end
  end

  always_comb begin
    byte_o = 8'h00;
    case (addr_i[1:0])
      2'd0:    byte_o = word_sel[7:0];
      2'd1:    byte_o = word_sel[15:8];
      2'd2:    byte_o = word_sel[23:16];
      default: byte_o = word_sel[31:24];
    endcase
  end

endmodule

// File: rtl/chacha_block_seq.sv
// -----------------------------------------------------------------------------
// chacha_block_seq
// Drives a byte-serial ChaCha20 block core to produce num_blocks blocks of
// keystream. Per block: LOAD writes the 64 initial state bytes, CALC waits for
// the core's ready flag, STREAM reads the 64 permuted bytes back and adds the
// initial state (feed-forward) byte-serially with a carry that restarts at each
// 32-bit word, NEXT advances the block counter.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_valid/ready   job request; accepted when both high (ready only in IDLE)
//   key, nonce        256-bit key, 96-bit nonce, registered on accept
//   ctr_init          initial 32-bit block counter
//   num_blocks        number of blocks to generate (0 = none, just done)
//   blk_data_in/addr/write   byte write port of the block core
//   blk_data_out      core read data for blk_addr (combinational in the core)
//   blk_ready         core finished its rounds
//   ks_data/valid/ready/last keystream byte stream towards the consumer
//   busy              job in progress (state != IDLE)
//   done              one-cycle pulse when a job finishes
// Keystream handshake: a byte transfers on a rising edge where ks_valid and
// ks_ready are both high. Once ks_valid is raised it stays high and ks_data /
// ks_last stay unchanged until that transfer happens.
// -----------------------------------------------------------------------------
module chacha_block_seq
  import chacha_pkg::*;
#(
  parameter int NBLK_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [255:0]      key,
  input  logic [95:0]       nonce,
  input  logic [31:0]       ctr_init,
  input  logic [NBLK_W-1:0] num_blocks,
  output logic [7:0]        blk_data_in,
  output logic [5:0]        blk_addr,
  output logic              blk_write,
  input  logic [7:0]        blk_data_out,
  input  logic              blk_ready,
  output logic [7:0]        ks_data,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic              ks_last,
  output logic              busy,
  output logic              done
);

  seq_state_e        state_q, state_d;
  // idx_q[6] set means all 64 bytes of the block have been issued
  logic [6:0]        idx_q, idx_d;
  logic [255:0]      key_q, key_d;
  logic [95:0]       nonce_q, nonce_d;
  logic [31:0]       ctr_q, ctr_d;
  logic [NBLK_W-1:0] rem_q, rem_d;
  logic              carry_q, carry_d;
  logic [7:0]        ks_data_q, ks_data_d;
  logic              ks_valid_q, ks_valid_d;
  logic              ks_last_q, ks_last_d;
  logic              done_q, done_d;

  logic [7:0]        layout_byte;
  logic              carry_in;
  logic [8:0]        sum;
  logic              ks_load;
  logic              last_acc;
  logic              rem_is_one;

  chacha_state_byte_mux u_byte_mux (
    .addr_i  (idx_q[5:0]),
    .key_i   (key_q),
    .nonce_i (nonce_q),
    .ctr_i   (ctr_q),
    .byte_o  (layout_byte)
  );

  assign rem_is_one = (rem_q == NBLK_W'(1));

  // Carry restarts at byte 0 of every word: the add is per 32-bit word.
  assign carry_in = (idx_q[1:0] != 2'd0) && carry_q;
  assign sum      = 9'(blk_data_out) + 9'(layout_byte) + 9'(carry_in);

  // Output register refills when empty or when its byte is being taken.
  assign ks_load  = (state_q == STREAM) && !idx_q[6] && (!ks_valid_q || ks_ready);
  // Byte 63 leaving the output register ends the block.
  assign last_acc = (state_q == STREAM) && idx_q[6] && ks_valid_q && ks_ready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    key_d      = key_q;
    nonce_d    = nonce_q;
    ctr_d      = ctr_q;
    rem_d      = rem_q;
    carry_d    = carry_q;
    ks_data_d  = ks_data_q;
    ks_valid_d = ks_valid_q;
    ks_last_d  = ks_last_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          key_d   = key;
          nonce_d = nonce;
          ctr_d   = ctr_init;
          rem_d   = num_blocks;
          idx_d   = 7'd0;
          carry_d = 1'b0;
          if (num_blocks == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        if (idx_q[5:0] == 6'd63) begin
          idx_d   = 7'd0;
          state_d = CALC;
        end else begin
          idx_d = idx_q + 7'd1;
        end
      end

      CALC: begin
        if (blk_ready) begin
          state_d = STREAM;
        end
      end

      STREAM: begin
        if (ks_load) begin
          ks_data_d  = sum[7:0];
          ks_valid_d = 1'b1;
          ks_last_d  = (idx_q[5:0] == 6'd63) && rem_is_one;
          carry_d    = sum[8];
          idx_d      = idx_q + 7'd1;
        end else if (last_acc) begin
          ks_valid_d = 1'b0;
          ks_last_d  = 1'b0;
          idx_d      = 7'd0;
          carry_d    = 1'b0;
          state_d    = NEXT;
          done_d     = rem_is_one;
        end
      end

      NEXT: begin
        ctr_d = ctr_q + 32'd1;
        rem_d = rem_q - NBLK_W'(1);
        if (rem_is_one) begin
          state_d = IDLE;
        end else begin
          state_d = LOAD;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 7'd0;
      key_q      <= '0;
      nonce_q    <= '0;
      ctr_q      <= '0;
      rem_q      <= '0;
      carry_q    <= 1'b0;
      ks_data_q  <= 8'h00;
      ks_valid_q <= 1'b0;
      ks_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      key_q      <= key_d;
      nonce_q    <= nonce_d;
      ctr_q      <= ctr_d;
      rem_q      <= rem_d;
      carry_q    <= carry_d;
      ks_data_q  <= ks_data_d;
      ks_valid_q <= ks_valid_d;
      ks_last_q  <= ks_last_d;
      done_q     <= done_d;
    end
  end

  assign cfg_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign blk_write   = (state_q == LOAD);
  assign blk_addr    = ((state_q == LOAD) || (state_q == STREAM)) ? idx_q[5:0] : 6'd0;
  assign blk_data_in = (state_q == LOAD) ? layout_byte : 8'h00;
  assign ks_data     = ks_data_q;
  assign ks_valid    = ks_valid_q;
  assign ks_last     = ks_last_q;

endmodule

// File: tb/tb_chacha_block_seq.sv
// -----------------------------------------------------------------------------
// tb_chacha_block_seq
// Bench for the ChaCha20 block sequencer with a behavioural byte-serial block
// core. Stimulus pushes expected keystream bytes (and expected load states)
// into queues; independent monitors pop and compare on every transfer.
// -----------------------------------------------------------------------------
module tb_chacha_block_seq;

  localparam int NBLK_W = 16;
  localparam int TMO    = 3000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [255:0]      key = '0;
  logic [95:0]       nonce = '0;
  logic [31:0]       ctr_init = '0;
  logic [NBLK_W-1:0] num_blocks = '0;
  logic [7:0]        blk_data_in;
  logic [5:0]        blk_addr;
  logic              blk_write;
  logic [7:0]        blk_data_out;
  logic              blk_ready;
  logic [7:0]        ks_data;
  logic              ks_valid;
  logic              ks_ready;
  logic              ks_last;
  logic              busy;
  logic              done;

  chacha_block_seq #(.NBLK_W(NBLK_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .key          (key),
    .nonce        (nonce),
    .ctr_init     (ctr_init),
    .num_blocks   (num_blocks),
    .blk_data_in  (blk_data_in),
    .blk_addr     (blk_addr),
    .blk_write    (blk_write),
    .blk_data_out (blk_data_out),
    .blk_ready    (blk_ready),
    .ks_data      (ks_data),
    .ks_valid     (ks_valid),
    .ks_ready     (ks_ready),
    .ks_last      (ks_last),
    .busy         (busy),
    .done         (done)
  );

  // ---------------- reference ChaCha20 (word level) ----------------
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a_i, b_i, c_i, d_i);
    logic [31:0] a, b, c, d;
    a = a_i; b = b_i; c = c_i; d = d_i;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {d, c, b, a};
  endfunction

  function automatic logic [511:0] rounds20(input logic [511:0] s);
    logic [31:0]  x[16];
    logic [511:0] o;
    for (int k = 0; k < 16; k++) x[k] = s[32*k +: 32];
    for (int r = 0; r < 10; r++) begin
      {x[12], x[8],  x[4], x[0]} = qr(x[0], x[4], x[8],  x[12]);
      {x[13], x[9],  x[5], x[1]} = qr(x[1], x[5], x[9],  x[13]);
      {x[14], x[10], x[6], x[2]} = qr(x[2], x[6], x[10], x[14]);
      {x[15], x[11], x[7], x[3]} = qr(x[3], x[7], x[11], x[15]);
      {x[15], x[10], x[5], x[0]} = qr(x[0], x[5], x[10], x[15]);
      {x[12], x[11], x[6], x[1]} = qr(x[1], x[6], x[11], x[12]);
      {x[13], x[8],  x[7], x[2]} = qr(x[2], x[7], x[8],  x[13]);
      {x[14], x[9],  x[4], x[3]} = qr(x[3], x[4], x[9],  x[14]);
    end
    for (int k = 0; k < 16; k++) o[32*k +: 32] = x[k];
    return o;
  endfunction

  function automatic logic [511:0] init_state(input logic [255:0] k, input logic [95:0] n,
                                              input logic [31:0] c);
    return {n, c, k, 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
  endfunction

  function automatic logic [511:0] keystream(input logic [511:0] st);
    logic [511:0] r, o;
    r = rounds20(st);
    for (int k = 0; k < 16; k++) o[32*k +: 32] = r[32*k +: 32] + st[32*k +: 32];
    return o;
  endfunction

  // ---------------- behavioural block core ----------------
  logic [511:0] core_in_v = '0;
  logic [511:0] core_out_v = '0;
  int           core_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_cnt  <= 0;
      blk_ready <= 1'b1;
    end else begin
      if (core_cnt == 1) begin
        core_out_v <= rounds20(core_in_v);
        blk_ready  <= 1'b1;
      end
      if (core_cnt > 0) core_cnt <= core_cnt - 1;
      if (blk_write) begin
        core_in_v[{blk_addr, 3'b000} +: 8] <= blk_data_in;
        blk_ready <= 1'b0;
        if (blk_addr == 6'd63) core_cnt <= 160;
      end
    end
  end

  assign blk_data_out = core_out_v[{blk_addr, 3'b000} +: 8];

  // ---------------- scoreboard state ----------------
  logic [7:0]   exp_q[$];
  logic         exp_last_q[$];
  logic [511:0] init_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  int exp_done = 0;
  int n_wr = 0;
  int acc_cnt = 0;
  int acc_base = 0;
  int hand_mode = 0;
  int blk_in_job = 0;
  int rdy_mode = 0;
  int stall_left = 0;
  bit stall_done = 1'b0;

  logic [7:0] rfc_hdr[8];
  initial begin
    rfc_hdr[0] = 8'h10; rfc_hdr[1] = 8'hf1; rfc_hdr[2] = 8'he7; rfc_hdr[3] = 8'he4;
    rfc_hdr[4] = 8'hd1; rfc_hdr[5] = 8'h3b; rfc_hdr[6] = 8'h59; rfc_hdr[7] = 8'h15;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- keystream monitor ----------------
  bit         hold_v = 1'b0;
  logic [8:0] hold_val;
  bit         done_chk = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v   = 1'b0;
      done_chk = 1'b0;
    end else begin
      if (done_chk) begin
        check("done_after_last", 64'(done), 64'd1);
        done_chk = 1'b0;
      end
      if (done) n_done++;
      if (hold_v) begin
        check("stall_valid", 64'(ks_valid), 64'd1);
        check("stall_hold", 64'({ks_last, ks_data}), 64'(hold_val));
      end
      hold_v   = ks_valid && !ks_ready;
      hold_val = {ks_last, ks_data};
      if (ks_valid && ks_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL ks_extra: got byte %0h, expected no byte", ks_data);
        end else begin
          logic [7:0] e;
          logic       el;
          e  = exp_q.pop_front();
          el = exp_last_q.pop_front();
          check("ks_data", 64'(ks_data), 64'(e));
          check("ks_last", 64'(ks_last), 64'(el));
          if (el) done_chk = 1'b1;
        end
        acc_cnt++;
      end
    end
  end

  // ---------------- load monitor ----------------
  logic [511:0] cur_init = '0;
  int           ld_idx = 0;

  always @(negedge clk) begin
    if (rst_n && blk_write) begin
      n_wr++;
      if (blk_addr == 6'd0) begin
        ld_idx = 0;
        blk_in_job++;
        if (init_q.size() > 0) cur_init = init_q.pop_front();
        else fail_now("ld_unexpected_block");
      end
      check("ld_addr", 64'(blk_addr), 64'(ld_idx));
      check("ld_data", 64'(blk_data_in), 64'(cur_init[8*ld_idx +: 8]));
      if (hand_mode == 1 && blk_in_job == 1) begin
        case (blk_addr)
          6'd0:  check("ld_hand_a0", 64'(blk_data_in), 64'h65);
          6'd1:  check("ld_hand_a1", 64'(blk_data_in), 64'h78);
          6'd2:  check("ld_hand_a2", 64'(blk_data_in), 64'h70);
          6'd3:  check("ld_hand_a3", 64'(blk_data_in), 64'h61);
          6'd48: check("ld_hand_ctr0", 64'(blk_data_in), 64'h01);
          6'd49, 6'd50, 6'd51: check("ld_hand_ctr", 64'(blk_data_in), 64'h00);
          6'd52, 6'd53, 6'd54: check("ld_hand_nonce", 64'(blk_data_in), 64'h00);
          6'd55: check("ld_hand_nonce3", 64'(blk_data_in), 64'h09);
          default: ;
        endcase
      end
      if (hand_mode == 2 && blk_addr >= 6'd48 && blk_addr <= 6'd51) begin
        if (blk_in_job == 1) check("ld_wrap_ctr_b1", 64'(blk_data_in), 64'hff);
        else                 check("ld_wrap_ctr_b2", 64'(blk_data_in), 64'h00);
      end
      ld_idx++;
    end
  end

  // ---------------- consumer ready driver ----------------
  initial begin
    ks_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) begin
        ks_ready = 1'b1;
      end else if (stall_left > 0) begin
        ks_ready = 1'b0;
        stall_left--;
      end else if (!stall_done && (acc_cnt - acc_base) == 5) begin
        stall_done = 1'b1;
        stall_left = 19;
        ks_ready   = 1'b0;
      end else begin
        ks_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_idle_outputs(input string name);
    check(name, 64'({cfg_ready, busy, done, ks_valid, ks_last, blk_write,
                     ks_data, blk_addr, blk_data_in}), 64'({1'b1, 27'd0}));
  endtask

  task automatic start_job(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                           input logic [NBLK_W-1:0] nb, input bit use_rfc);
    logic [511:0] st, ksv;
    logic [31:0]  cc;
    int           cyc;
    cc = c;
    for (int b = 0; b < int'(nb); b++) begin
      st  = init_state(k, n, cc);
      ksv = keystream(st);
      init_q.push_back(st);
      for (int i = 0; i < 64; i++) begin
        if (use_rfc && b == 0 && i < 8) exp_q.push_back(rfc_hdr[i]);
        else                            exp_q.push_back(ksv[8*i +: 8]);
        exp_last_q.push_back((b == int'(nb) - 1) && (i == 63));
      end
      cc = cc + 32'd1;
    end
    exp_done++;
    blk_in_job = 0;
    cyc = 0;
    @(negedge clk);
    while (!cfg_ready && cyc < TMO) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= TMO) fail_now("cfg_ready_timeout");
    cfg_valid  = 1'b1;
    key        = k;
    nonce      = n;
    ctr_init   = c;
    num_blocks = nb;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    if (nb == '0) begin
      @(negedge clk);
      check("zero_blk_done", 64'(done), 64'd1);
    end
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while ((busy || exp_q.size() != 0) && cyc < TMO);
    if (cyc >= TMO) fail_now({name, "_timeout"});
    @(negedge clk);
    check({name, "_bytes_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done_cnt"}, 64'(n_done), 64'(exp_done));
  endtask

  // ---------------- main stimulus ----------------
  logic [255:0] rfc_key;
  logic [95:0]  rfc_nonce;
  int           wr_snap, done_snap;

  initial begin
    for (int j = 0; j < 32; j++) rfc_key[8*j +: 8] = 8'(j);
    rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};

    // reset state
    #12;
    check_idle_outputs("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("idle_after_reset");

    // RFC 8439 block, consumer always ready
    hand_mode = 1;
    rdy_mode  = 0;
    start_job(rfc_key, rfc_nonce, 32'd1, 16'd1, 1'b1);
    wait_idle("rfc");

    // same block under random backpressure with a long stall at byte 5
    rdy_mode   = 1;
    acc_base   = acc_cnt;
    stall_done = 1'b0;
    start_job(rfc_key, rfc_nonce, 32'd1, 16'd1, 1'b1);
    wait_idle("bp");
    rdy_mode = 0;
    check("bp_byte_count", 64'(acc_cnt - acc_base), 64'd64);
    check("bp_stall_hit", 64'(stall_done), 64'd1);

    // two blocks, counter wraps; cfg requests during the job are ignored
    hand_mode = 2;
    acc_base  = acc_cnt;
    start_job({8{32'hdeadbeef}} ^ rfc_key, {32'h12345678, 32'h9abcdef0, 32'h0badf00d},
              32'hffffffff, 16'd2, 1'b0);
    repeat (80) @(negedge clk);
    cfg_valid  = 1'b1;
    key        = '1;
    num_blocks = 16'd5;
    for (int i = 0; i < 5; i++) begin
      check("cfg_ready_busy", 64'(cfg_ready), 64'd0);
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    wait_idle("wrap");
    check("wrap_byte_count", 64'(acc_cnt - acc_base), 64'd128);
    hand_mode = 0;

    // zero blocks: done pulse, no core writes
    wr_snap = n_wr;
    start_job(rfc_key, rfc_nonce, 32'd7, 16'd0, 1'b0);
    repeat (5) @(negedge clk);
    check("zero_blk_no_write", 64'(n_wr), 64'(wr_snap));
    check("zero_blk_done_cnt", 64'(n_done), 64'(exp_done));
    check("zero_blk_busy", 64'(busy), 64'd0);

    // reset while the core is computing
    start_job(rfc_key, rfc_nonce, 32'd1, 16'd1, 1'b1);
    repeat (100) @(negedge clk);
    check("in_calc", 64'({busy, blk_write, ks_valid}), 64'b100);
    done_snap = n_done;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort_outputs");
    exp_q.delete();
    exp_last_q.delete();
    init_q.delete();
    exp_done--;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("abort_idle");
    check("abort_no_done", 64'(n_done), 64'(done_snap));

    // fresh job after abort
    hand_mode = 1;
    start_job(rfc_key, rfc_nonce, 32'd1, 16'd1, 1'b1);
    wait_idle("fresh");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
